// File: rtl/ram_pkg.sv
// Shared constants for the 4002-style RAM array: bus phases, I/O opcodes,
// wishbone slot map and small opcode-classification helpers.
package ram_pkg;

    // Bus phase numbers within the 8-clock instruction frame
    localparam logic [2:0] CYC_OPA = 3'd4;
    localparam logic [2:0] CYC_SRC = 3'd6;
    localparam logic [2:0] CYC_EXE = 3'd6;
    localparam logic [2:0] CYC_X3  = 3'd7;

    // I/O opcodes that act on the RAM chip
    localparam logic [3:0] OP_WRM = 4'h0;
    localparam logic [3:0] OP_WMP = 4'h1;
    localparam logic [3:0] OP_SBM = 4'h8;
    localparam logic [3:0] OP_RDM = 4'h9;
    localparam logic [3:0] OP_ADM = 4'hB;

    // Wishbone slot map inside one chip's 16-word window
    localparam logic [3:0] SLOT_STAT = 4'd8;
    localparam logic [3:0] SLOT_OUT  = 4'd10;

    // Opcodes that place a main-memory character on the CPU bus
    function automatic logic op_reads_mem(input logic [3:0] op);
        return (op == OP_SBM) || (op == OP_RDM) || (op == OP_ADM);
    endfunction

    // WR0..WR3: write a status character
    function automatic logic op_writes_status(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

    // RD0..RD3: drive a status character
    function automatic logic op_reads_status(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/ram_chip.sv
// One 4002-style data RAM chip: SRC/opcode decode, 4x16 character memory,
// 4x4 status characters, 4-bit output port and a wishbone backdoor port.
module ram_chip
    import ram_pkg::*;
#(
    parameter int CHIP_ID = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cyc,
    input  logic        cmd_n,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    output logic [3:0]  out,
    input  logic        wb_go,
    input  logic        wb_hit,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [3:0]  wb_slot,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o
);

    localparam logic [1:0] ID = 2'(CHIP_ID);

    logic       sel;
    logic       src;
    logic [1:0] reg_addr;
    logic [3:0] char_addr;
    logic [3:0] inst;
    logic       inst_active;
    logic [3:0] mem [64];
    logic [3:0] status [16];
    logic [31:0] rd_word;
    logic       exec;
    logic [5:0] mem_idx;
    logic [3:0] stat_idx;

    assign exec     = (cyc == CYC_EXE) && inst_active;
    assign mem_idx  = {reg_addr, char_addr};
    assign stat_idx = {reg_addr, inst[1:0]};

    // Chip selection, address latching and instruction tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            sel         <= 1'b0;
            src         <= 1'b0;
            reg_addr    <= 2'd3;
            char_addr   <= 4'hF;
            inst        <= 4'h0;
            inst_active <= 1'b0;
        end else begin
            if (cyc == CYC_SRC && !cmd_n) begin
                if (data_i[3:2] == ID) begin
                    sel      <= 1'b1;
                    src      <= 1'b1;
                    reg_addr <= data_i[1:0];
                end else begin
                    sel <= 1'b0;
                    src <= 1'b0;
                end
            end
            if (cyc == CYC_X3 && cmd_n) begin
                inst_active <= 1'b0;
                if (src) begin
                    char_addr <= data_i;
                    src       <= 1'b0;
                end
            end
            if (cyc == CYC_OPA && !cmd_n && sel) begin
                inst        <= data_i;
                inst_active <= 1'b1;
            end
        end
    end

    // CPU reads drive the bus combinationally during the execute phase
    always_comb begin
        data_o  = 4'h0;
        data_en = 1'b0;
        if (exec) begin
            if (op_reads_mem(inst)) begin
                data_en = 1'b1;
                data_o  = mem[mem_idx];
            end else if (op_reads_status(inst)) begin
                data_en = 1'b1;
                data_o  = status[stat_idx];
            end
        end
    end

    // Assemble the 32-bit backdoor view of the addressed slot
    always_comb begin
        rd_word = 32'h0;
        for (int j = 0; j < 8; j++) begin
            if (!wb_slot[3]) begin
                rd_word[4*j +: 4] = mem[{wb_slot[2:0], 3'(j)}];
            end else if ((wb_slot & 4'hE) == SLOT_STAT) begin
                rd_word[4*j +: 4] = status[{wb_slot[0], 3'(j)}];
            end
        end
        if (wb_slot == SLOT_OUT) begin
            rd_word[3:0] = out;
        end
    end

    // Storage updates: CPU writes land on the cyc 6 edge, wishbone on cyc 7
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 4'h0;
            end
            for (int i = 0; i < 16; i++) begin
                status[i] <= 4'h0;
            end
            out       <= 4'h0;
            wb_data_o <= 32'h0;
        end else begin
            if (exec) begin
                if (inst == OP_WRM) begin
                    mem[mem_idx] <= data_i;
                end
                if (inst == OP_WMP) begin
                    out <= data_i;
                end
                if (op_writes_status(inst)) begin
                    status[stat_idx] <= data_i;
                end
            end
            // Non-addressed chips load zero so the top-level OR yields the hit
            if (wb_go) begin
                wb_data_o <= wb_hit ? rd_word : 32'h0;
            end
            if (wb_hit && wb_we) begin
                for (int j = 0; j < 8; j++) begin
                    if (wb_sel[2'(j / 2)]) begin
                        if (!wb_slot[3]) begin
                            mem[{wb_slot[2:0], 3'(j)}] <= wb_data_i[4*j +: 4];
                        end else if ((wb_slot & 4'hE) == SLOT_STAT) begin
                            status[{wb_slot[0], 3'(j)}] <= wb_data_i[4*j +: 4];
                        end else if (wb_slot == SLOT_OUT && j == 0) begin
                            out <= wb_data_i[3:0];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ram_array.sv
// Bank of 4002-style RAM chips on the 4-bit CPU bus, NUM_BANKS CM-RAM lines by
// CHIPS_PER_BANK chips, with a packed 32-bit wishbone backdoor.
module ram_array
    import ram_pkg::*;
#(
    parameter int NUM_BANKS      = 1,
    parameter int CHIPS_PER_BANK = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [3:0]                            data_i,
    output logic [3:0]                            data_o,
    output logic                                  data_en,
    input  logic                                  sync,
    input  logic [NUM_BANKS-1:0]                  cmd_n,
    output logic [4*NUM_BANKS*CHIPS_PER_BANK-1:0] out,
    input  logic [31:0]                           wb_data_i,
    input  logic [31:0]                           wb_addr_i,
    input  logic [3:0]                            wb_sel_i,
    input  logic                                  wb_cyc_i,
    input  logic                                  wb_strobe_i,
    input  logic                                  wb_we_i,
    output logic [31:0]                           wb_data_o,
    output logic                                  wb_ack_o
);

    localparam int NCHIP = NUM_BANKS * CHIPS_PER_BANK;

    logic [2:0]       cyc;
    logic             wb_go;
    logic [25:0]      wb_chip;
    logic [3:0]       wb_slot;
    logic [NCHIP-1:0] wb_hit;
    logic [NCHIP-1:0] chip_en;
    logic [3:0]       chip_data [NCHIP];
    logic [31:0]      chip_wb [NCHIP];
    logic             unused_ok;

    // The CPU sync line and byte-offset bits carry no information here
    assign unused_ok = ^{sync, wb_addr_i[1:0]};

    // One backdoor access per frame, serviced on the cyc 7 edge
    assign wb_go   = (cyc == CYC_X3) && wb_cyc_i && wb_strobe_i && !wb_ack_o;
    assign wb_chip = wb_addr_i[31:6];
    assign wb_slot = wb_addr_i[5:2];

    // Free-running frame phase counter
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc <= 3'd0;
        end else begin
            cyc <= cyc + 3'd1;
        end
    end

    // Ack is a single-cycle pulse following the service edge; out-of-range
    // chips are acked too and read as zero
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
        end else begin
            wb_ack_o <= wb_go;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar c = 0; c < CHIPS_PER_BANK; c++) begin : g_chip
            localparam int K = b * CHIPS_PER_BANK + c;

            assign wb_hit[K] = wb_go && (wb_chip == 26'(K));

            ram_chip #(
                .CHIP_ID(c)
            ) u_chip (
                .clock     (clock),
                .reset     (reset),
                .cyc       (cyc),
                .cmd_n     (cmd_n[b]),
                .data_i    (data_i),
                .data_o    (chip_data[K]),
                .data_en   (chip_en[K]),
                .out       (out[4*K +: 4]),
                .wb_go     (wb_go),
                .wb_hit    (wb_hit[K]),
                .wb_we     (wb_we_i),
                .wb_sel    (wb_sel_i),
                .wb_slot   (wb_slot),
                .wb_data_i (wb_data_i),
                .wb_data_o (chip_wb[K])
            );
        end
    end

    // Merge chip outputs; idle chips contribute zero
    always_comb begin
        data_o    = 4'h0;
        wb_data_o = 32'h0;
        for (int k = 0; k < NCHIP; k++) begin
            data_o    = data_o | chip_data[k];
            wb_data_o = wb_data_o | chip_wb[k];
        end
        data_en = |chip_en;
    end

endmodule

// File: tb/tb_ram_array.sv
// Self-checking bench for ram_array (2 banks x 2 chips): directed scenarios
// followed by randomized CPU/wishbone traffic against a transaction-level model.
module tb_ram_array;

    localparam int NB    = 2;
    localparam int CPB   = 2;
    localparam int NCHIP = NB * CPB;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        data_i = 4'h0;
    logic [3:0]        data_o;
    logic              data_en;
    logic              sync = 1'b0;
    logic [NB-1:0]     cmd_n = '1;
    logic [4*NCHIP-1:0] out;
    logic [31:0]       wb_data_i = 32'h0;
    logic [31:0]       wb_addr_i = 32'h0;
    logic [3:0]        wb_sel_i = 4'h0;
    logic              wb_cyc_i = 1'b0;
    logic              wb_strobe_i = 1'b0;
    logic              wb_we_i = 1'b0;
    logic [31:0]       wb_data_o;
    logic              wb_ack_o;

    int checks = 0;
    int errors = 0;

    // Frame phase as the bus protocol defines it
    logic [2:0] tb_cyc = 3'd0;

    // Reference model: per-chip storage, per-bank selection
    logic [3:0] m_mem  [NCHIP][64];
    logic [3:0] m_stat [NCHIP][16];
    logic [3:0] m_out  [NCHIP];
    int         m_selchip [NB];
    int         m_reg [NB];
    int         m_char [NB];

    ram_array #(.NUM_BANKS(NB), .CHIPS_PER_BANK(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_i      (data_i),
        .data_o      (data_o),
        .data_en     (data_en),
        .sync        (sync),
        .cmd_n       (cmd_n),
        .out         (out),
        .wb_data_i   (wb_data_i),
        .wb_addr_i   (wb_addr_i),
        .wb_sel_i    (wb_sel_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_strobe_i (wb_strobe_i),
        .wb_we_i     (wb_we_i),
        .wb_data_o   (wb_data_o),
        .wb_ack_o    (wb_ack_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) tb_cyc <= 3'd0;
        else       tb_cyc <= tb_cyc + 3'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCHIP; k++) begin
            for (int i = 0; i < 64; i++) m_mem[k][i] = 4'h0;
            for (int i = 0; i < 16; i++) m_stat[k][i] = 4'h0;
            m_out[k] = 4'h0;
        end
        for (int b = 0; b < NB; b++) begin
            m_selchip[b] = -1;
            m_reg[b]     = 3;
            m_char[b]    = 15;
        end
    endtask

    function automatic logic [31:0] model_wb_read(input logic [31:0] addr);
        logic [31:0] w;
        int k;
        int s;
        w = 32'h0;
        k = int'(addr[31:6]);
        s = int'(addr[5:2]);
        if (k < NCHIP) begin
            for (int j = 0; j < 8; j++) begin
                if (s < 8)               w = w | (32'(m_mem[k][8*s + j]) << (4*j));
                else if (s == 8 || s == 9) w = w | (32'(m_stat[k][8*(s-8) + j]) << (4*j));
            end
            if (s == 10) w = 32'(m_out[k]);
        end
        return w;
    endfunction

    task automatic model_wb_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd);
        int k;
        int s;
        logic [3:0] nib;
        k = int'(addr[31:6]);
        s = int'(addr[5:2]);
        if (k < NCHIP) begin
            for (int j = 0; j < 8; j++) begin
                nib = 4'((wd >> (4*j)) & 32'hF);
                if (sel[j/2]) begin
                    if (s < 8)                 m_mem[k][8*s + j] = nib;
                    else if (s == 8 || s == 9) m_stat[k][8*(s-8) + j] = nib;
                    else if (s == 10 && j == 0) m_out[k] = nib;
                end
            end
        end
    endtask

    function automatic logic [4*NCHIP-1:0] model_out();
        logic [4*NCHIP-1:0] v;
        v = '0;
        for (int k = 0; k < NCHIP; k++) v = v | ((4*NCHIP)'(m_out[k]) << (4*k));
        return v;
    endfunction

    // Advance to the next clock period whose phase is p (sampled at negedge)
    task automatic goto(input logic [2:0] p);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tb_cyc != p && n < 16);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        cmd_n = '1;
        data_i = 4'h0;
        wb_cyc_i = 1'b0;
        wb_strobe_i = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic cpu_src(input int bank, input int id, input int r, input int ch);
        goto(3'd6);
        cmd_n  = ~(NB'(1) << bank);
        data_i = 4'((id << 2) | r);
        goto(3'd7);
        cmd_n  = '1;
        data_i = 4'(ch);
        goto(3'd0);
        data_i = 4'h0;
        if (id < CPB) begin
            m_selchip[bank] = id;
            m_reg[bank]     = r;
            m_char[bank]    = ch;
        end else begin
            m_selchip[bank] = -1;
        end
    endtask

    task automatic cpu_io(input int bank, input int op, input int d);
        int k;
        logic       exp_en;
        logic [3:0] exp_d;
        goto(3'd4);
        cmd_n  = ~(NB'(1) << bank);
        data_i = 4'(op);
        goto(3'd6);
        cmd_n  = '1;
        data_i = 4'(d);
        exp_en = 1'b0;
        exp_d  = 4'h0;
        k = -1;
        if (m_selchip[bank] >= 0) begin
            k = bank * CPB + m_selchip[bank];
            if (op == 8 || op == 9 || op == 11) begin
                exp_en = 1'b1;
                exp_d  = m_mem[k][m_reg[bank]*16 + m_char[bank]];
            end else if (op >= 12) begin
                exp_en = 1'b1;
                exp_d  = m_stat[k][m_reg[bank]*4 + (op - 12)];
            end
        end
        chk("cpu_data_en", 32'(data_en), 32'(exp_en));
        chk("cpu_data_o", 32'(data_o), 32'(exp_d));
        goto(3'd7);
        data_i = 4'h0;
        if (k >= 0) begin
            if (op == 0)                m_mem[k][m_reg[bank]*16 + m_char[bank]] = 4'(d);
            else if (op == 1)           m_out[k] = 4'(d);
            else if (op >= 4 && op <= 7) m_stat[k][m_reg[bank]*4 + (op - 4)] = 4'(d);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, output logic [31:0] rd);
        int n = 0;
        @(negedge clock);
        wb_addr_i   = addr;
        wb_we_i     = we;
        wb_sel_i    = sel;
        wb_data_i   = wd;
        wb_cyc_i    = 1'b1;
        wb_strobe_i = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!wb_ack_o && n < 12);
        chk("wb_ack_seen", 32'(wb_ack_o), 32'd1);
        chk("wb_ack_phase", 32'(tb_cyc), 32'd0);
        rd = wb_data_o;
        wb_cyc_i    = 1'b0;
        wb_strobe_i = 1'b0;
        wb_we_i     = 1'b0;
        @(negedge clock);
        chk("wb_ack_pulse", 32'(wb_ack_o), 32'd0);
        if (we) model_wb_write(addr, sel, wd);
    endtask

    function automatic logic [31:0] wb_addr(input int k, input int s);
        return 32'((k << 6) | (s << 2));
    endfunction

    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;

    initial begin
        model_clear();
        do_reset(3);

        // Reset state
        chk("rst_data_en", 32'(data_en), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_wb_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        for (int s = 0; s < 16; s++) begin
            wb_xfer(wb_addr(0, s), 1'b0, 4'h0, 32'h0, rd);
            chk("rst_chip0_slot", rd, 32'h0);
        end

        // Bank 0 SRC 0x6 selects chip 1, reg 2; char 5; WRM 0xA
        cpu_src(0, 1, 2, 5);
        cpu_io(0, 0, 4'hA);
        wb_xfer(wb_addr(1, 4), 1'b0, 4'h0, 32'h0, rd);
        chk("wrm_chip1_slot4", rd, 32'h00A00000);
        chk("wrm_chip1_slot4_model", rd, model_wb_read(wb_addr(1, 4)));
        wb_xfer(wb_addr(1, 2), 1'b0, 4'h0, 32'h0, rd);
        chk("wrm_chip1_slot2", rd, 32'h0);
        wb_xfer(wb_addr(0, 4), 1'b0, 4'h0, 32'h0, rd);
        chk("wrm_chip0_slot4", rd, 32'h0);

        // Independent bank selection
        cpu_src(1, 0, 1, 3);
        cpu_src(0, 1, 0, 0);
        cpu_io(1, 6, 4'h3);
        cpu_io(1, 14, 4'h0);
        wb_xfer(wb_addr(2, 8), 1'b0, 4'h0, 32'h0, rd);
        chk("wr2_chip2_status", rd, 32'h03000000);

        // WMP to chip 3
        cpu_src(1, 1, 0, 0);
        cpu_io(1, 1, 4'h9);
        @(negedge clock);
        chk("wmp_out", 32'(out), 32'h00009000);
        wb_xfer(wb_addr(3, 10), 1'b0, 4'h0, 32'h0, rd);
        chk("wmp_slot10", rd, 32'h00000009);

        // Byte-enable write
        wb_xfer(wb_addr(0, 0), 1'b1, 4'b0101, 32'h87654321, rd);
        wb_xfer(wb_addr(0, 0), 1'b0, 4'h0, 32'h0, rd);
        chk("wb_sel_write", rd, 32'h00650021);

        // Reset between opcode and execute aborts instruction and WB request
        cpu_src(0, 1, 0, 2);
        cpu_io(0, 4, 4'h7);
        goto(3'd4);
        cmd_n       = ~(NB'(1));
        data_i      = 4'hC;
        wb_addr_i   = wb_addr(1, 8);
        wb_we_i     = 1'b0;
        wb_cyc_i    = 1'b1;
        wb_strobe_i = 1'b1;
        goto(3'd5);
        cmd_n  = '1;
        data_i = 4'h7;
        reset  = 1'b1;
        @(negedge clock);
        chk("abort_data_en_rst", 32'(data_en), 32'd0);
        wb_cyc_i    = 1'b0;
        wb_strobe_i = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("abort_data_en", 32'(data_en), 32'd0);
            chk("abort_no_ack", 32'(wb_ack_o), 32'd0);
        end
        data_i = 4'h0;
        wb_xfer(wb_addr(1, 8), 1'b0, 4'h0, 32'h0, rd);
        chk("abort_status_cleared", rd, 32'h0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: cpu_src($urandom_range(0, NB-1), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 15));
                1: cpu_io($urandom_range(0, NB-1), $urandom_range(0, 15), $urandom_range(0, 15));
                2: begin
                    a  = wb_addr($urandom_range(0, NCHIP+1), $urandom_range(0, 15)) | 32'($urandom_range(0, 3));
                    wd = $urandom;
                    wb_xfer(a, 1'b1, 4'($urandom_range(0, 15)), wd, rd);
                end
                default: begin
                    a = wb_addr($urandom_range(0, NCHIP+1), $urandom_range(0, 15));
                    wb_xfer(a, 1'b0, 4'h0, 32'h0, rd);
                    chk("rand_wb_read", rd, model_wb_read(a));
                end
            endcase
        end

        // Full backdoor sweep against the model
        @(negedge clock);
        chk("final_out", 32'(out), 32'(model_out()));
        for (int k = 0; k <= NCHIP; k++) begin
            for (int s = 0; s < 12; s++) begin
                wb_xfer(wb_addr(k, s), 1'b0, 4'h0, 32'h0, rd);
                chk("final_sweep", rd, model_wb_read(wb_addr(k, s)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
